// File: rtl/intr_controller.sv
// Interrupt controller: latches/masks device IRQs and runs a req/ack/EOI handshake with the CPU.
// Define INTC_EDGE_DETECT_EN for rising-edge capture of irqIn; default build is level-sensitive.
module intr_controller #(
  parameter int ABUS_WIDTH = 32,
  parameter int DBUS_WIDTH = 32,
  parameter int NUM_SRC = 4,
  parameter logic [ABUS_WIDTH-1:0] BASE_ADDR = 32'hF0000200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ABUS_WIDTH-1:0] aBus,
  inout  logic [DBUS_WIDTH-1:0] dBus,
  input  logic                  wrtEn,
  input  logic [NUM_SRC-1:0]    irqIn,
  output logic                  intReq,
  output logic [3:0]            intId,
  input  logic                  intAck
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } stateT;

  stateT state, stateNext;
  logic [NUM_SRC-1:0] ipend, imask, ipendNext;
  logic               gie;
  logic               latchId;

  // Register window decode: four word registers at BASE_ADDR + {0,4,8,C}.
  logic [ABUS_WIDTH-1:0] offset;
  logic                  hit;
  logic [1:0]            regSel;
  logic                  wrIpend, wrImask, wrIctrl, wrIid, rdEn;

  assign offset  = aBus - BASE_ADDR;
  assign hit     = (offset[ABUS_WIDTH-1:4] == '0) && (offset[1:0] == 2'b00);
  assign regSel  = offset[3:2];
  assign wrIpend = wrtEn && hit && (regSel == 2'd0);
  assign wrImask = wrtEn && hit && (regSel == 2'd1);
  assign wrIctrl = wrtEn && hit && (regSel == 2'd2);
  assign wrIid   = wrtEn && hit && (regSel == 2'd3);
  assign rdEn    = hit && !wrtEn;

  logic unusedBits;
  assign unusedBits = ^dBus[DBUS_WIDTH-1:NUM_SRC];

  // Per-source "set" events feeding IPEND.
  logic [NUM_SRC-1:0] srcSet;
`ifdef INTC_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] irqReg, irqRegD;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irqReg  <= '0;
      irqRegD <= '0;
    end else begin
      irqReg  <= irqIn;
      irqRegD <= irqReg;
    end
  end

  assign srcSet = irqReg & ~irqRegD;
`else
  assign srcSet = irqIn;
`endif

  // Priority select, IPEND update and liveness of the currently requested source.
  logic [NUM_SRC-1:0] eligible, ackClr, w1cClr;
  logic [3:0]         lowestId;
  logic               curLive;

  assign eligible = gie ? (ipend & imask) : '0;
  assign w1cClr   = wrIpend ? dBus[NUM_SRC-1:0] : '0;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    lowestId = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) lowestId = 4'(i);
    end
  end

  always_comb begin
    ackClr  = '0;
    curLive = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (intId == 4'(i)) begin
        ackClr[i] = (state == REQ) && intAck;
        curLive   = ipend[i] & imask[i];
      end
    end
  end

  // A new source event wins over a same-edge W1C or acknowledge clear.
  assign ipendNext = (ipend & ~(w1cClr | ackClr)) | srcSet;

  always_comb begin
    stateNext = state;
    latchId   = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          stateNext = REQ;
          latchId   = 1'b1;
        end
      end
      REQ: begin
        if (intAck) stateNext = SERVICE;
        else if (!gie || !curLive) stateNext = IDLE;
      end
      SERVICE: begin
        if (wrIid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ipend  <= '0;
      imask  <= '0;
      gie    <= 1'b0;
      intId  <= '0;
      intReq <= 1'b0;
    end else begin
      ipend  <= ipendNext;
      intReq <= (stateNext == REQ);
      if (wrImask) imask <= dBus[NUM_SRC-1:0];
      if (wrIctrl) gie <= dBus[0];
      if (latchId) intId <= lowestId;
    end
  end

  // Combinational read mux; the bus is released whenever this block is not being read.
  logic [DBUS_WIDTH-1:0] rdData;

  always_comb begin
    rdData = '0;
    case (regSel)
      2'd0: rdData[NUM_SRC-1:0] = ipend;
      2'd1: rdData[NUM_SRC-1:0] = imask;
      2'd2: rdData[2:0] = {state == SERVICE, state == REQ, gie};
      default: rdData[3:0] = intId;
    endcase
  end

  assign dBus = rdEn ? rdData : {DBUS_WIDTH{1'bz}};

endmodule

// File: tb/tb_intr_controller.sv
// Scoreboard bench for intr_controller: stimulus pushes expected request IDs and register reads,
// a negedge monitor pops and compares when the DUT raises intReq or a read is presented.
module tb_intr_controller;

  localparam logic [31:0] A_IPEND = 32'hF0000200;
  localparam logic [31:0] A_IMASK = 32'hF0000204;
  localparam logic [31:0] A_ICTRL = 32'hF0000208;
  localparam logic [31:0] A_IID   = 32'hF000020C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] aBus = '0;
  wire  [31:0] dBus;
  logic        wrtEn = 1'b0;
  logic [3:0]  irqIn = '0;
  logic        intReq;
  logic [3:0]  intId;
  logic        intAck = 1'b0;

  logic [31:0] dDrv = '0;
  logic        dEn = 1'b0;
  assign dBus = dEn ? dDrv : 32'hzzzzzzzz;

  always #5 clk = ~clk;

  intr_controller dut (
    .clk    (clk),
    .reset  (reset),
    .aBus   (aBus),
    .dBus   (dBus),
    .wrtEn  (wrtEn),
    .irqIn  (irqIn),
    .intReq (intReq),
    .intId  (intId),
    .intAck (intAck)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] val;
    bit          isZ;
  } rdExpT;

  rdExpT rdQ[$];
  int    reqQ[$];
  logic  rdStrobe = 1'b0;
  logic  prevReq = 1'b0;
  rdExpT monE;
  int    monId;

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  always @(negedge clk) begin
    if (rdStrobe) begin
      if (rdQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %h expected no read", dBus);
      end else begin
        monE = rdQ.pop_front();
        if (monE.isZ) begin
          checks++;
          if (!(dBus === 32'hzzzzzzzz || dBus === 32'h0)) begin
            failures++;
            $display("FAIL %s: got %h expected high-Z", monE.name, dBus);
          end
        end else begin
          check(monE.name, dBus, monE.val);
        end
      end
    end
    if (intReq && !prevReq) begin
      if (reqQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL req_unexpected: got intReq with id %0d expected none", intId);
      end else begin
        monId = reqQ.pop_front();
        check("req_id", {28'b0, intId}, monId);
      end
    end
    prevReq <= intReq;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // All driver tasks start and end 1ns after a rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    aBus = addr; dDrv = data; dEn = 1'b1; wrtEn = 1'b1;
    tick();
    wrtEn = 1'b0; dEn = 1'b0; aBus = '0;
  endtask

  task automatic busRead(input string name, input logic [31:0] addr, input logic [31:0] exp);
    rdExpT e;
    e.name = name; e.val = exp; e.isZ = 1'b0;
    rdQ.push_back(e);
    aBus = addr; rdStrobe = 1'b1;
    tick();
    rdStrobe = 1'b0; aBus = '0;
  endtask

  task automatic zRead(input string name);
    rdExpT e;
    e.name = name; e.val = '0; e.isZ = 1'b1;
    rdQ.push_back(e);
    aBus = '0; rdStrobe = 1'b1;
    tick();
    rdStrobe = 1'b0;
  endtask

  task automatic waitReq(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (intReq) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic ackPulse();
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    check("req_drop_after_ack", {31'b0, intReq}, 32'd0);
  endtask

  initial begin
    logic [3:0] mask, raised;
    bit         gieFirst;
    int         ids[$];

    tick(2);
    reset = 1'b1;
    check("reset_intReq", {31'b0, intReq}, 32'd0);
    check("reset_intId", {28'b0, intId}, 32'd0);
    busRead("reset_ipend", A_IPEND, 32'd0);
    busRead("reset_imask", A_IMASK, 32'd0);
    busRead("reset_ictrl", A_ICTRL, 32'd0);
    busRead("reset_iid", A_IID, 32'd0);
    zRead("reset_dbus_z");

    // Request latency and basic handshake on source 0.
    busWrite(A_IMASK, 32'h1);
    busWrite(A_ICTRL, 32'h1);
    irqIn = 4'b0001;
    reqQ.push_back(0);
    tick();
    check("lat_after_edgeN", {31'b0, intReq}, 32'd0);
`ifdef INTC_EDGE_DETECT_EN
    tick();
    check("lat_edge_extra_cycle", {31'b0, intReq}, 32'd0);
`endif
    tick();
    check("lat_req_up", {31'b0, intReq}, 32'd1);
    check("lat_id", {28'b0, intId}, 32'd0);
    irqIn = '0;
    ackPulse();
    busRead("svc_ictrl", A_ICTRL, 32'h5);
    busRead("svc_ipend_cleared", A_IPEND, 32'h0);
    busRead("svc_iid", A_IID, 32'h0);
    busWrite(A_IID, 32'h0);
    busRead("eoi_ictrl", A_ICTRL, 32'h1);

    // Simultaneous sources 1 and 3: lower index first, then 3 after EOI.
    busWrite(A_IMASK, 32'hF);
    irqIn = 4'b1010;
    reqQ.push_back(1);
    reqQ.push_back(3);
    tick();
    irqIn = '0;
    waitReq("prio_req1");
    busRead("prio_iid1", A_IID, 32'd1);
    ackPulse();
    busWrite(A_IID, 32'hDEAD);
    waitReq("prio_req3");
    busRead("prio_iid3", A_IID, 32'd3);
    ackPulse();
    busWrite(A_IID, 32'h0);

    // Disabling GIE while in REQ withdraws the request but keeps IPEND.
    irqIn = 4'b0100;
    reqQ.push_back(2);
    tick();
    irqIn = '0;
    waitReq("gieoff_req");
    busWrite(A_ICTRL, 32'h0);
    check("gieoff_still_req", {31'b0, intReq}, 32'd1);
    tick();
    check("gieoff_dropped", {31'b0, intReq}, 32'd0);
    busRead("gieoff_ictrl", A_ICTRL, 32'h0);
    busRead("gieoff_ipend", A_IPEND, 32'h4);
    busWrite(A_IPEND, 32'h4);
    busRead("gieoff_ipend_clr", A_IPEND, 32'h0);

    // W1C colliding with a new event on the same bit: set wins.
    irqIn = 4'b0010;
    tick();
    irqIn = '0;
    tick(2);
    busRead("coll_pre", A_IPEND, 32'h2);
    irqIn = 4'b0010;
`ifdef INTC_EDGE_DETECT_EN
    tick();
`endif
    busWrite(A_IPEND, 32'h2);
    irqIn = '0;
    tick(2);
    busRead("coll_set_wins", A_IPEND, 32'h2);
    zRead("idle_dbus_z");
    busWrite(A_IPEND, 32'h2);
    busRead("coll_w1c_alone", A_IPEND, 32'h0);

    // Held-high source 0 across ack and EOI.
    busWrite(A_IMASK, 32'h1);
    busWrite(A_ICTRL, 32'h1);
    irqIn = 4'b0001;
    reqQ.push_back(0);
    waitReq("held_req");
    ackPulse();
`ifdef INTC_EDGE_DETECT_EN
    busRead("held_ipend_svc", A_IPEND, 32'h0);
    busWrite(A_IID, 32'h0);
    tick(6);
    check("held_edge_no_rereq", {31'b0, intReq}, 32'd0);
    irqIn = '0;
    busWrite(A_ICTRL, 32'h0);
`else
    busRead("held_ipend_svc", A_IPEND, 32'h1);
    reqQ.push_back(0);
    busWrite(A_IID, 32'h0);
    waitReq("held_level_rereq");
    busWrite(A_ICTRL, 32'h0);
    tick();
    check("held_level_drop", {31'b0, intReq}, 32'd0);
    irqIn = '0;
    busWrite(A_IPEND, 32'hFFFFFFFF);
`endif
    busRead("held_ipend_end", A_IPEND, 32'h0);

    // Reset while in SERVICE with another source still pending.
    busWrite(A_IMASK, 32'hF);
    busWrite(A_ICTRL, 32'h1);
    irqIn = 4'b0110;
    reqQ.push_back(1);
    tick();
    irqIn = '0;
    waitReq("midrst_req");
    ackPulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_intReq", {31'b0, intReq}, 32'd0);
    check("midrst_intId", {28'b0, intId}, 32'd0);
    busRead("midrst_ipend", A_IPEND, 32'h0);
    busRead("midrst_imask", A_IMASK, 32'h0);
    busRead("midrst_ictrl", A_ICTRL, 32'h0);
    tick(4);
    check("midrst_quiet", {31'b0, intReq}, 32'd0);

    // Randomised rounds: expected service order is the ascending set bits of raised & mask.
    for (int r = 0; r < 24; r++) begin
      mask     = 4'($urandom_range(1, 15));
      raised   = 4'($urandom_range(1, 15));
      gieFirst = 1'($urandom_range(0, 1));
      ids.delete();
      for (int i = 0; i < 4; i++) begin
        if (raised[i] && mask[i]) begin
          ids.push_back(i);
          reqQ.push_back(i);
        end
      end
      busWrite(A_IMASK, {28'b0, mask});
      if (gieFirst) busWrite(A_ICTRL, 32'h1);
      irqIn = raised;
      tick();
      irqIn = '0;
      tick(2);
      if (!gieFirst) begin
        busRead("rnd_ipend_pre", A_IPEND, {28'b0, raised});
        busRead("rnd_imask", A_IMASK, {28'b0, mask});
        busWrite(A_ICTRL, 32'h1);
      end
      foreach (ids[k]) begin
        waitReq("rnd_req");
        tick($urandom_range(0, 3));
        busRead("rnd_iid", A_IID, ids[k]);
        ackPulse();
        busRead("rnd_ictrl_svc", A_ICTRL, 32'h5);
        tick($urandom_range(0, 2));
        busWrite(A_IID, $urandom);
      end
      tick(4);
      check("rnd_no_extra_req", {31'b0, intReq}, 32'd0);
      busRead("rnd_ipend_left", A_IPEND, {28'b0, raised & ~mask});
      busWrite(A_ICTRL, 32'h0);
      busWrite(A_IPEND, 32'hFFFFFFFF);
      busRead("rnd_ipend_clr", A_IPEND, 32'h0);
    end

    tick(2);
    check("reqQ_drained", reqQ.size(), 32'd0);
    check("rdQ_drained", rdQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
